ps2_scan_receiver: RTL and testbench

Receives PS/2 keyboard frames from the raw `ps2_clk`/`ps2_data` lines and folds the E0 (extended) and F0 (break) prefix bytes into one 10-bit scan-code word. Each completed code is presented with a single-cycle strobe. It sits between the board PS/2 pins and the key-decode logic. Its `data[9:0]` output is the word that the key-decode logic compares and cases on: bit 9 = extended, bit 8 = break, bits 7:0 = code.

---
 rtl/ps2_scan_receiver.sv | 155 +++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame receiver folding E0/F0 prefixes into a {ext, brk, code} word
module ps2_scan_receiver #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [9:0] data,
   output logic       ready,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int IW = $clog2(TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;
   state_t        state_q, state_d;
   logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
   logic          fclk_q, fclk_d, fall;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [IW-1:0] icnt_q, icnt_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d, stop_q, stop_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic [9:0]    data_q, data_d;
   logic          ready_q, ready_d, ferr_q, ferr_d;
   logic          sclk, sdat;
   assign sclk      = csync_q[1];
   assign sdat      = dsync_q[1];
   assign data      = data_q;
   assign ready     = ready_q;
   assign frame_err = ferr_q;
   // synchronize the pins and debounce the clock; fall marks the cycle fclk drops
   always_comb begin
      csync_d = {csync_q[0], ps2_clk};
      dsync_d = {dsync_q[0], ps2_data};
      fclk_d  = fclk_q;
      fcnt_d  = '0;
      fall    = 1'b0;
      if (sclk != fclk_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            fclk_d = sclk;
            fall   = fclk_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end
   // frame sequencing, prefix folding and mid-frame timeout
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      stop_d  = stop_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      icnt_d  = '0;
      case (state_q)
         IDLE: begin
            if (fall && !sdat) begin
               bcnt_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               shreg_d = {sdat, shreg_q[7:1]};
               bcnt_d  = bcnt_q + 3'd1;
               state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = sdat;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               stop_d  = sdat;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!(^shreg_q ^ par_q) || !stop_q) begin
               ferr_d = 1'b1;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
            end else if (shreg_q == 8'hE0) begin
               ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
               brk_d = 1'b1;
            end else begin
               data_d  = {ext_q, brk_q, shreg_q};
               ready_d = 1'b1;
               ext_d   = 1'b0;
               brk_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == DATA || state_q == PARITY || state_q == STOP) && !fall) begin
         if (icnt_q == IW'(TIMEOUT - 1)) begin
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = IDLE;
         end else begin
            icnt_d = icnt_q + IW'(1);
         end
      end
   end
   // state register; pin-side flops reset to the idle-high line level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         csync_q <= 2'b11;
         dsync_q <= 2'b11;
         fclk_q  <= 1'b1;
         fcnt_q  <= '0;
         icnt_q  <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         stop_q  <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         csync_q <= csync_d;
         dsync_q <= dsync_d;
         fclk_q  <= fclk_d;
         fcnt_q  <= fcnt_d;
         icnt_q  <= icnt_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         stop_q  <= stop_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
      end
   end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: random and directed PS/2 frames checked against a byte-level prefix model
module tb_ps2_scan_receiver;
   localparam int FL = 4;
   localparam int TO = 300;
   logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [9:0] data;
   logic       ready, frame_err;
   int         cyc = 0, n_chk = 0, n_err = 0;
   int         rdy_cnt = 0, err_cnt = 0, rdy_cyc = 0, err_cyc = 0, both_cnt = 0, unstable_cnt = 0;
   int         stop_cyc = 0;
   logic [9:0] prev_data = '0;
   logic       m_ext = 1'b0, m_brk = 1'b0;
   logic [9:0] m_data = '0;

   ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data(data), .ready(ready), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   // cycle counter for latency measurements
   always @(posedge clk) cyc <= cyc + 1;
   // output monitor sampled mid-cycle
   always @(negedge clk) begin
      if (ready) begin
         rdy_cnt++;
         rdy_cyc = cyc;
      end
      if (frame_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (ready && frame_err) both_cnt++;
      if (rst_n && !ready && data !== prev_data) unstable_cnt++;
      prev_data = data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b, input bit bad, input int nbits, input int half, input int glitch_at);
      logic [10:0] f;
      f = {1'b1, ~(^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (half) @(negedge clk);
         if (i == glitch_at) begin
            ps2_clk = 1'b0;
            repeat (FL - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (half) @(negedge clk);
         end
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (half) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (half) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input bit bad, input int half, input int glitch_at);
      int r0, e0;
      bit rd, er;
      r0 = rdy_cnt;
      e0 = err_cnt;
      rd = 1'b0;
      er = 1'b0;
      if (bad) begin
         er = 1'b1;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         rd = 1'b1;
         m_data = {m_ext, m_brk, b};
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      drive(b, bad, 11, half, glitch_at);
      chk("ready_pulses", rdy_cnt - r0, rd);
      chk("err_pulses", err_cnt - e0, er);
      chk("data", data, m_data);
      if (rd) chk("ready_latency", rdy_cyc - stop_cyc, FL + 3);
      if (er) chk("err_latency", err_cyc - stop_cyc, FL + 3);
   endtask

   initial begin
      int r0, e0;
      repeat (3) @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_ready", ready, 0);
      chk("rst_err", frame_err, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      frame(8'h1C, 0, 10, -1);
      frame(8'hF0, 0, 10, -1);
      frame(8'h1C, 0, 10, -1);
      frame(8'h23, 0, 10, -1);
      frame(8'hE0, 0, 10, -1);
      frame(8'hF0, 0, 10, -1);
      frame(8'h74, 0, 10, -1);
      frame(8'hE0, 0, 10, -1);
      frame(8'h6B, 0, 10, -1);
      frame(8'hE0, 0, 10, -1);
      frame(8'h1D, 1, 10, -1);
      frame(8'h1D, 0, 10, -1);
      frame(8'h44, 0, 10, 0);
      frame(8'h44, 0, 10, 5);
      frame(8'hE0, 0, 10, -1);
      r0 = rdy_cnt;
      e0 = err_cnt;
      drive(8'h5A, 0, 6, 10, -1);
      repeat (TO + 40) @(negedge clk);
      m_ext = 1'b0;
      m_brk = 1'b0;
      chk("timeout_err", err_cnt - e0, 1);
      chk("timeout_ready", rdy_cnt - r0, 0);
      chk("timeout_data", data, m_data);
      frame(8'h5A, 0, 10, -1);
      frame(8'hE0, 0, 10, -1);
      drive(8'h12, 0, 4, 10, -1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_data", data, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_err", frame_err, 0);
      rst_n = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_data = '0;
      repeat (20) @(negedge clk);
      frame(8'h66, 0, 10, -1);
      for (int k = 0; k < 40; k++) begin
         int sel;
         logic [7:0] b;
         sel = $urandom_range(0, 9);
         b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         frame(b, $urandom_range(0, 7) == 0, $urandom_range(FL + 4, 14),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
      end
      chk("both_high", both_cnt, 0);
      chk("data_unstable", unstable_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
